// File: rtl/ifu_fetch.sv
// Instruction fetch unit: sequential PC generation, single-outstanding imem requests,
// prefetch FIFO of {inst, pc} toward the core, and flush on control-flow redirect.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h8000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        fetch_pc_q, fetch_pc_d;
   logic [31:0]        req_pc_q, req_pc_d;
   logic               req_valid_q, req_valid_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [31:0]        inst_mem_q [FIFO_DEPTH];
   logic [31:0]        pc_mem_q   [FIFO_DEPTH];

   logic               req_fire;
   logic               push;
   logic               pop;
   logic               unused_pc_lsbs;

   assign unused_pc_lsbs = ^redirect_pc[1:0];

   assign req_fire = req_valid_q & imem_req_ready;
   assign push     = (state_q == S_WAIT) & imem_rsp_valid & ~redirect_valid;
   assign pop      = (count_q != '0) & inst_ready & ~redirect_valid;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      if (redirect_valid) begin
         // A request accepted or still in flight must have its response swallowed.
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         case (state_q)
            S_REQ:   state_d = req_fire ? S_DROP : S_REQ;
            default: state_d = imem_rsp_valid ? S_REQ : S_DROP;
         endcase
      end else begin
         case (state_q)
            S_REQ: begin
               if (req_fire) begin
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  req_pc_d   = fetch_pc_q;
                  state_d    = S_WAIT;
               end
            end
            default: begin
               if (imem_rsp_valid) state_d = S_REQ;
            end
         endcase
      end

      // Full check uses the post-update count, so a same-cycle pop never earns credit early.
      req_valid_d = (state_d == S_REQ) && (count_d < DEPTH_CNT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_REQ;
         fetch_pc_q  <= RESET_PC;
         req_pc_q    <= '0;
         req_valid_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         req_pc_q    <= req_pc_d;
         req_valid_q <= req_valid_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            inst_mem_q[i] <= '0;
            pc_mem_q[i]   <= '0;
         end
      end else if (push) begin
         inst_mem_q[wr_ptr_q] <= imem_rsp_data;
         pc_mem_q[wr_ptr_q]   <= req_pc_q;
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = fetch_pc_q;
   assign inst_valid     = (count_q != '0);
   assign inst           = inst_mem_q[rd_ptr_q];
   assign inst_pc        = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a 1..N cycle in-order memory model returning addr^0x13,
// logs of accepted requests and delivered instructions, and hand-computed expectations.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   int          n_total = 0;
   int          n_bad   = 0;
   int          cyc     = 0;
   int          rsp_delay;

   logic [31:0] req_log [$];
   int          req_cyc [$];
   logic [31:0] dlv_pc  [$];
   logic [31:0] dlv_inst[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ifu_fetch #(
      .RESET_PC   (32'h8000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
      end else begin
         $display("ok   %s: %08h", tag, got);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      req_log.delete();
      req_cyc.delete();
      dlv_pc.delete();
      dlv_inst.delete();
   endtask

   // Leaves the bench 1 time unit after the last reset edge, reset released.
   task automatic do_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      step(3);
      reset = 1'b0;
      clear_logs();
   endtask

   // Memory model: accepts on valid&ready, answers exactly rsp_delay cycles later.
   initial begin
      logic        fire_n;
      logic        busy;
      logic [31:0] addr_n;
      logic [31:0] pend_addr;
      int          cnt;
      fire_n = 1'b0;
      busy = 1'b0;
      addr_n = '0;
      pend_addr = '0;
      cnt = 0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         fire_n = imem_req_valid && imem_req_ready && !reset;
         addr_n = imem_req_addr;
         if (fire_n) begin
            req_log.push_back(addr_n);
            req_cyc.push_back(cyc);
         end
         @(posedge clk);
         #1;
         imem_rsp_valid = 1'b0;
         if (reset) begin
            busy = 1'b0;
         end else begin
            if (fire_n) begin
               busy      = 1'b1;
               pend_addr = addr_n;
               cnt       = rsp_delay;
            end
            if (busy) begin
               cnt--;
               if (cnt == 0) begin
                  imem_rsp_valid = 1'b1;
                  imem_rsp_data  = pend_addr ^ 32'h13;
                  busy           = 1'b0;
               end
            end
         end
      end
   end

   // Core side: record every word actually consumed.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset && inst_valid && inst_ready && !redirect_valid) begin
            dlv_pc.push_back(inst_pc);
            dlv_inst.push_back(inst);
         end
      end
   end

   initial begin
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      rsp_delay      = 1;

      // Reset state
      step(2);
      chk("rst req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst inst_valid", 32'(inst_valid), 32'd0);
      chk("rst inst", inst, 32'h0);
      chk("rst inst_pc", inst_pc, 32'h0);
      chk("rst req_addr", imem_req_addr, 32'h8000_0000);

      // Streaming with a 1-cycle memory
      do_reset();
      step(1);
      chk("t1 req_valid c1", 32'(imem_req_valid), 32'd1);
      chk("t1 req_addr c1", imem_req_addr, 32'h8000_0000);
      chk("t1 inst_valid c1", 32'(inst_valid), 32'd0);
      step(1);
      chk("t1 req_valid c2", 32'(imem_req_valid), 32'd0);
      chk("t1 inst_valid c2", 32'(inst_valid), 32'd0);
      step(1);
      chk("t1 inst_valid c3", 32'(inst_valid), 32'd1);
      chk("t1 inst_pc c3", inst_pc, 32'h8000_0000);
      chk("t1 inst c3", inst, 32'h8000_0013);
      step(6);
      chk("t1 req count", 32'(req_log.size()), 32'd4);
      chk("t1 req0", req_log[0], 32'h8000_0000);
      chk("t1 req1", req_log[1], 32'h8000_0004);
      chk("t1 req2", req_log[2], 32'h8000_0008);
      chk("t1 req gap01", 32'(req_cyc[1] - req_cyc[0]), 32'd2);
      chk("t1 req gap12", 32'(req_cyc[2] - req_cyc[1]), 32'd2);
      chk("t1 dlv count", 32'(dlv_pc.size()), 32'd3);
      chk("t1 dlv pc0", dlv_pc[0], 32'h8000_0000);
      chk("t1 dlv pc1", dlv_pc[1], 32'h8000_0004);
      chk("t1 dlv pc2", dlv_pc[2], 32'h8000_0008);
      chk("t1 dlv inst0", dlv_inst[0], 32'h8000_0013);
      chk("t1 dlv inst1", dlv_inst[1], 32'h8000_0017);
      chk("t1 dlv inst2", dlv_inst[2], 32'h8000_001B);

      // Back-pressure: FIFO fills to depth, head holds, then drains in order
      inst_ready = 1'b0;
      do_reset();
      step(6);
      chk("t2 inst_valid full", 32'(inst_valid), 32'd1);
      chk("t2 head pc c6", inst_pc, 32'h8000_0000);
      chk("t2 head inst c6", inst, 32'h8000_0013);
      chk("t2 req_valid full", 32'(imem_req_valid), 32'd0);
      step(4);
      chk("t2 head pc c10", inst_pc, 32'h8000_0000);
      chk("t2 head inst c10", inst, 32'h8000_0013);
      chk("t2 req_valid c10", 32'(imem_req_valid), 32'd0);
      chk("t2 req count", 32'(req_log.size()), 32'd2);
      inst_ready = 1'b1;
      step(1);
      chk("t2 resume valid", 32'(imem_req_valid), 32'd1);
      chk("t2 resume addr", imem_req_addr, 32'h8000_0008);
      step(5);
      chk("t2 dlv >=3", 32'(dlv_pc.size() >= 3), 32'd1);
      chk("t2 dlv pc0", dlv_pc[0], 32'h8000_0000);
      chk("t2 dlv pc1", dlv_pc[1], 32'h8000_0004);
      chk("t2 dlv pc2", dlv_pc[2], 32'h8000_0008);
      chk("t2 dlv inst1", dlv_inst[1], 32'h8000_0017);
      chk("t2 req2", req_log[2], 32'h8000_0008);

      // Redirect while waiting on a 3-cycle response
      rsp_delay = 3;
      do_reset();
      step(2);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0103;
      step(1);
      redirect_valid = 1'b0;
      chk("t3 req_valid drop", 32'(imem_req_valid), 32'd0);
      chk("t3 inst_valid drop", 32'(inst_valid), 32'd0);
      step(2);
      chk("t3 req_valid after", 32'(imem_req_valid), 32'd1);
      chk("t3 req_addr after", imem_req_addr, 32'h8000_0100);
      chk("t3 inst_valid after", 32'(inst_valid), 32'd0);
      step(7);
      chk("t3 req count", 32'(req_log.size()), 32'd3);
      chk("t3 req1", req_log[1], 32'h8000_0100);
      chk("t3 dlv count", 32'(dlv_pc.size()), 32'd1);
      chk("t3 dlv pc0", dlv_pc[0], 32'h8000_0100);
      chk("t3 dlv inst0", dlv_inst[0], 32'h8000_0113);

      // Redirect coincident with a request handshake
      rsp_delay = 1;
      do_reset();
      step(1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0200;
      step(1);
      redirect_valid = 1'b0;
      chk("t4a req_valid", 32'(imem_req_valid), 32'd0);
      chk("t4a inst_valid", 32'(inst_valid), 32'd0);
      step(1);
      chk("t4a inst_valid drop", 32'(inst_valid), 32'd0);
      chk("t4a req_valid next", 32'(imem_req_valid), 32'd1);
      chk("t4a req_addr next", imem_req_addr, 32'h8000_0200);
      step(4);
      chk("t4a req1", req_log[1], 32'h8000_0200);
      chk("t4a dlv count", 32'(dlv_pc.size()), 32'd1);
      chk("t4a dlv pc0", dlv_pc[0], 32'h8000_0200);
      chk("t4a dlv inst0", dlv_inst[0], 32'h8000_0213);

      // Redirect coincident with a response, FIFO holding one word, pop attempted
      inst_ready = 1'b0;
      do_reset();
      step(4);
      chk("t4b inst_valid pre", 32'(inst_valid), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0300;
      inst_ready     = 1'b1;
      step(1);
      redirect_valid = 1'b0;
      chk("t4b inst_valid flush", 32'(inst_valid), 32'd0);
      chk("t4b req_valid", 32'(imem_req_valid), 32'd1);
      chk("t4b req_addr", imem_req_addr, 32'h8000_0300);
      step(4);
      chk("t4b dlv count", 32'(dlv_pc.size()), 32'd1);
      chk("t4b dlv pc0", dlv_pc[0], 32'h8000_0300);
      chk("t4b dlv inst0", dlv_inst[0], 32'h8000_0313);

      // Address wrap at the top of the 32-bit space
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      step(1);
      redirect_valid = 1'b0;
      chk("t5 req_valid", 32'(imem_req_valid), 32'd1);
      chk("t5 req_addr", imem_req_addr, 32'hFFFF_FFFC);
      step(7);
      chk("t5 req count", 32'(req_log.size()), 32'd4);
      chk("t5 req0", req_log[0], 32'hFFFF_FFFC);
      chk("t5 req1", req_log[1], 32'h0000_0000);
      chk("t5 dlv count", 32'(dlv_pc.size()), 32'd3);
      chk("t5 dlv pc0", dlv_pc[0], 32'hFFFF_FFFC);
      chk("t5 dlv inst0", dlv_inst[0], 32'hFFFF_FFEF);
      chk("t5 dlv pc1", dlv_pc[1], 32'h0000_0000);
      chk("t5 dlv inst1", dlv_inst[1], 32'h0000_0013);

      // Reset while a request is outstanding and the FIFO is occupied
      inst_ready = 1'b0;
      do_reset();
      step(4);
      chk("t6 inst_valid pre", 32'(inst_valid), 32'd1);
      reset = 1'b1;
      step(1);
      chk("t6 inst_valid rst", 32'(inst_valid), 32'd0);
      chk("t6 req_valid rst", 32'(imem_req_valid), 32'd0);
      chk("t6 inst rst", inst, 32'h0);
      chk("t6 inst_pc rst", inst_pc, 32'h0);
      chk("t6 req_addr rst", imem_req_addr, 32'h8000_0000);
      step(2);
      reset = 1'b0;
      clear_logs();
      inst_ready = 1'b1;
      step(1);
      chk("t6 req_valid rel", 32'(imem_req_valid), 32'd1);
      chk("t6 req_addr rel", imem_req_addr, 32'h8000_0000);
      step(2);
      chk("t6 req count", 32'(req_log.size()), 32'd1);
      chk("t6 req0", req_log[0], 32'h8000_0000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
